// File: rtl/writeback_pipe.sv
// Writeback stage of a barrel-threaded core: registers the M-to-W boundary,
// formats load data, and keeps per-thread retired-instruction counters.
module writeback_pipe #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int NUM_THREADS   = 8,
   parameter int CNT_WIDTH     = 32,
   localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_m,
   input  logic                     flush_m,
   input  logic                     reg_write_m,
   input  logic [1:0]               result_src_m,
   input  logic [DATA_WIDTH-1:0]    alu_result_m,
   input  logic [DATA_WIDTH-1:0]    read_data_m,
   input  logic [2:0]               load_funct3_m,
   input  logic [DATA_WIDTH-1:0]    imm_m,
   input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
   input  logic [4:0]               rd_m,
   input  logic [BITS_THREADS-1:0]  tid_m,
   input  logic                     instret_clr,
   input  logic [BITS_THREADS-1:0]  instret_clr_tid,
   input  logic [BITS_THREADS-1:0]  instret_sel,
   output logic                     valid_w,
   output logic                     reg_write_w,
   output logic [4:0]               rd_w,
   output logic [BITS_THREADS-1:0]  tid_w,
   output logic [DATA_WIDTH-1:0]    result_w,
   output logic [CNT_WIDTH-1:0]     instret_out
);

   logic                  retire_m;
   logic [1:0]            off;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [DATA_WIDTH-1:0] result_m;
   logic [CNT_WIDTH-1:0]  cnt [NUM_THREADS];

   assign retire_m = valid_m & ~flush_m;
   assign off      = alu_result_m[1:0];

   // Misaligned accesses are not trapped: halfwords ignore off[0], words ignore off.
   always_comb begin
      load_byte = read_data_m[7:0];
      case (off)
         2'd0: load_byte = read_data_m[7:0];
         2'd1: load_byte = read_data_m[15:8];
         2'd2: load_byte = read_data_m[23:16];
         2'd3: load_byte = read_data_m[31:24];
         default: load_byte = read_data_m[7:0];
      endcase
      load_half = off[1] ? read_data_m[31:16] : read_data_m[15:0];
   end

   always_comb begin
      load_ext = {{(DATA_WIDTH-32){read_data_m[31]}}, read_data_m[31:0]};
      case (load_funct3_m)
         3'b000: load_ext = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         3'b100: load_ext = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         3'b001: load_ext = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
         3'b101: load_ext = {{(DATA_WIDTH-16){1'b0}}, load_half};
         default: load_ext = {{(DATA_WIDTH-32){read_data_m[31]}}, read_data_m[31:0]};
      endcase
   end

   always_comb begin
      result_m = alu_result_m;
      case (result_src_m)
         2'd0: result_m = alu_result_m;
         2'd1: result_m = load_ext;
         2'd2: result_m = DATA_WIDTH'(pc_plus4_m);
         2'd3: result_m = imm_m;
         default: result_m = alu_result_m;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_w     <= 1'b0;
         reg_write_w <= 1'b0;
         rd_w        <= '0;
         tid_w       <= '0;
         result_w    <= '0;
      end else begin
         valid_w     <= retire_m;
         reg_write_w <= retire_m & reg_write_m & (rd_m != 5'd0);
         rd_w        <= rd_m;
         tid_w       <= tid_m;
         result_w    <= result_m;
      end
   end

   // Clear takes precedence over a same-thread retire on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_THREADS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            if (instret_clr && (instret_clr_tid == BITS_THREADS'(i)))
               cnt[i] <= '0;
            else if (retire_m && (tid_m == BITS_THREADS'(i)))
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // Selects past the last thread match no entry and read zero.
   always_comb begin
      instret_out = '0;
      for (int i = 0; i < NUM_THREADS; i++)
         if (instret_sel == BITS_THREADS'(i)) instret_out = cnt[i];
   end

endmodule
